// File: rtl/menu_pkg.sv
// Shared constants, FSM encoding and menu artwork for menu_index_fetch.
// Optional highlight blink is enabled by defining MENU_BLINK_EN.
package menu_pkg;

    localparam int IMG_W     = 160;
    localparam int IMG_H     = 120;
    localparam int ROM_DEPTH = IMG_W * IMG_H;

    localparam logic [3:0] INDEX_BG = 4'h4;
    localparam logic [3:0] INDEX_HL = 4'h3;

    localparam int BLINK_LOG2 = 4;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    // Inclusive screen-space button bounds, element b is button b.
    localparam logic [2:0][9:0] BTN_X0 = {10'd240, 10'd240, 10'd240};
    localparam logic [2:0][9:0] BTN_X1 = {10'd399, 10'd399, 10'd399};
    localparam logic [2:0][9:0] BTN_Y0 = {10'd320, 10'd260, 10'd200};
    localparam logic [2:0][9:0] BTN_Y1 = {10'd359, 10'd299, 10'd239};

    typedef enum logic [1:0] {SEL0, SEL1, SEL2, LOCKED} menu_sel_t;

    // Menu image texel at a ROM address: dithered backdrop, a title
    // band, and three bordered button faces drawn with INDEX_BG.
    function automatic logic [3:0] menu_texel(input logic [14:0] a);
        int ai;
        int tx;
        int ty;
        int x0;
        int x1;
        int y0;
        int y1;
        logic [3:0] t;
        ai = int'(a);
        tx = ai % IMG_W;
        ty = ai / IMG_W;
        t  = 4'h7 ^ {ty[0], 2'b00, tx[0]};
        if (ty >= 10 && ty < 20 && tx >= 40 && tx < 120)
            t = 4'h2;
        for (int b = 0; b < 3; b++) begin
            x0 = int'(BTN_X0[b]) / 4;
            x1 = int'(BTN_X1[b]) / 4;
            y0 = int'(BTN_Y0[b]) / 4;
            y1 = int'(BTN_Y1[b]) / 4;
            if (tx >= x0 && tx <= x1 && ty >= y0 && ty <= y1)
                t = (tx == x0 || tx == x1 || ty == y0 || ty == y1)
                    ? 4'h1 : INDEX_BG;
        end
        if (ai >= ROM_DEPTH)
            t = 4'h0;
        return t;
    endfunction

endpackage

// File: rtl/menu_rom.sv
// 19200x4 synchronous-read menu image ROM, one-cycle read latency.
// Contents come from menu_texel; the read register is not reset.
module menu_rom
    import menu_pkg::*;
(
    input  logic        Clk,
    input  logic [14:0] addr,
    output logic [3:0]  data
);

    // Registered read so the ROM maps onto block memory.
    always_ff @(posedge Clk)
        data <= menu_texel(addr);

endmodule

// File: rtl/menu_index_fetch.sv
// Pixel-to-palette-index pipeline with keyboard button selection.
// Define MENU_BLINK_EN to make the highlight blink every 16 frames.
module menu_index_fetch
    import menu_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank_in,
    input  logic       menu_en,
    input  logic [7:0] keycode,
    output logic [3:0] index_out,
    output logic       blank_out,
    output logic [1:0] sel_id,
    output logic       sel_valid
);

    menu_sel_t   state;
    logic [7:0]  key_prev;
    logic        key_edge;
    logic [1:0]  sel_up;
    logic [1:0]  sel_dn;
    logic        hl_on;
    logic        in_range;
    logic [2:0]  in_btn;
    logic        sel_btn;
    logic [14:0] addr_c;
    logic [14:0] s1_addr;
    logic        s1_hit;
    logic        s1_blank;
    logic        s2_hit;
    logic        s2_blank;
    logic [3:0]  rom_data;

    assign in_range = (DrawX < 10'd640) && (DrawY < 10'd480);
    assign addr_c   = in_range
        ? 15'(DrawY[9:2]) * 15'(IMG_W) + 15'(DrawX[9:2])
        : '0;

    // Which button rectangles contain the current pixel.
    always_comb begin
        for (int b = 0; b < 3; b++)
            in_btn[b] = in_range
                && DrawX >= BTN_X0[b] && DrawX <= BTN_X1[b]
                && DrawY >= BTN_Y0[b] && DrawY <= BTN_Y1[b];
    end

    // Pick the rectangle belonging to the selected button.
    always_comb begin
        sel_btn = 1'b0;
        case (sel_id)
            2'd0:    sel_btn = in_btn[0];
            2'd1:    sel_btn = in_btn[1];
            2'd2:    sel_btn = in_btn[2];
            default: sel_btn = 1'b0;
        endcase
    end

`ifdef MENU_BLINK_EN
    logic [BLINK_LOG2:0] frame_cnt;

    // Count frames at the top-left pixel to pace the blink.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            frame_cnt <= '0;
        else if (DrawX == 10'd0 && DrawY == 10'd0)
            frame_cnt <= frame_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
    end

    assign hl_on = frame_cnt[BLINK_LOG2] || (state == LOCKED);
`else
    assign hl_on = 1'b1;
`endif

    // Stage 1: address, highlight eligibility and blank.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_addr  <= '0;
            s1_hit   <= 1'b0;
            s1_blank <= 1'b0;
        end else begin
            s1_addr  <= addr_c;
            s1_hit   <= sel_btn && hl_on;
            s1_blank <= blank_in;
        end
    end

    menu_rom u_rom (
        .Clk  (Clk),
        .addr (s1_addr),
        .data (rom_data)
    );

    // Stage 2: carry side info alongside the ROM read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_hit   <= 1'b0;
            s2_blank <= 1'b0;
        end else begin
            s2_hit   <= s1_hit;
            s2_blank <= s1_blank;
        end
    end

    // Stage 3: highlight substitution and blanking.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            index_out <= '0;
            blank_out <= 1'b0;
        end else begin
            blank_out <= s2_blank;
            if (!s2_blank)
                index_out <= '0;
            else if (s2_hit && rom_data == INDEX_BG)
                index_out <= INDEX_HL;
            else
                index_out <= rom_data;
        end
    end

    assign key_edge = (keycode != 8'h00) && (key_prev == 8'h00);
    assign sel_up   = (sel_id == 2'd0) ? 2'd2 : sel_id - 2'd1;
    assign sel_dn   = (sel_id == 2'd2) ? 2'd0 : sel_id + 2'd1;

    // Selection FSM; leaving the menu overrides any key press.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= SEL0;
            sel_id    <= 2'd0;
            sel_valid <= 1'b0;
            key_prev  <= 8'h00;
        end else begin
            key_prev  <= keycode;
            sel_valid <= 1'b0;
            if (!menu_en) begin
                state  <= SEL0;
                sel_id <= 2'd0;
            end else if (key_edge && state != LOCKED) begin
                unique case (1'b1)
                    keycode == KEY_W: begin
                        state  <= menu_sel_t'(sel_up);
                        sel_id <= sel_up;
                    end
                    keycode == KEY_S: begin
                        state  <= menu_sel_t'(sel_dn);
                        sel_id <= sel_dn;
                    end
                    keycode == KEY_ENTER: begin
                        state     <= LOCKED;
                        sel_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_menu_index_fetch.sv
// Self-checking bench for menu_index_fetch against a screen-level model.
// Runs the default build (MENU_BLINK_EN undefined).
module tb_menu_index_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       blank_in = 1'b0;
    logic       menu_en = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [3:0] index_out;
    logic       blank_out;
    logic [1:0] sel_id;
    logic       sel_valid;

    int n_cmp = 0;
    int n_bad = 0;

    menu_index_fetch dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank_in  (blank_in),
        .menu_en   (menu_en),
        .keycode   (keycode),
        .index_out (index_out),
        .blank_out (blank_out),
        .sel_id    (sel_id),
        .sel_valid (sel_valid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Picture seen on screen, described in screen pixels.
    function automatic logic [3:0] img(input int x, input int y);
        int tx;
        int ty;
        int yb;
        logic [3:0] r;
        if (x >= 640 || y >= 480) begin
            x = 0;
            y = 0;
        end
        tx = x / 4;
        ty = y / 4;
        r = 4'h7 ^ 4'((ty % 2) * 8 + (tx % 2));
        if (x >= 160 && x < 480 && y >= 40 && y < 80)
            r = 4'h2;
        for (int b = 0; b < 3; b++) begin
            yb = 200 + 60 * b;
            if (x >= 240 && x <= 399 && y >= yb && y <= yb + 39)
                r = (x < 244 || x >= 396 || y < yb + 4 || y >= yb + 36)
                    ? 4'h1 : 4'h4;
        end
        return r;
    endfunction

    function automatic bit in_button(input int x, input int y,
                                     input int b);
        int yb;
        yb = 200 + 60 * b;
        return x < 640 && y < 480 && x >= 240 && x <= 399
               && y >= yb && y <= yb + 39;
    endfunction

    logic [3:0] m_idx [3] = '{default: 4'h0};
    logic       m_blk [3] = '{default: 1'b0};
    int         m_sel = 0;
    bit         m_locked = 0;
    bit         m_valid = 0;
    logic [7:0] m_kprev = 8'h00;

    // Reference model: 3-deep output queue plus selection behaviour.
    always @(posedge Clk or negedge Reset_n) begin
        logic [3:0] px;
        logic [3:0] im;
        bit         edge_k;
        if (!Reset_n) begin
            m_idx    = '{default: 4'h0};
            m_blk    = '{default: 1'b0};
            m_sel    = 0;
            m_locked = 0;
            m_valid  = 0;
            m_kprev  = 8'h00;
        end else begin
            im = img(int'(DrawX), int'(DrawY));
            if (!blank_in)
                px = 4'h0;
            else if (in_button(int'(DrawX), int'(DrawY), m_sel)
                     && im == 4'h4)
                px = 4'h3;
            else
                px = im;
            m_idx[2] = m_idx[1];
            m_idx[1] = m_idx[0];
            m_idx[0] = px;
            m_blk[2] = m_blk[1];
            m_blk[1] = m_blk[0];
            m_blk[0] = blank_in;
            edge_k   = keycode != 8'h00 && m_kprev == 8'h00;
            m_kprev  = keycode;
            m_valid  = 0;
            if (!menu_en) begin
                m_sel    = 0;
                m_locked = 0;
            end else if (edge_k && !m_locked) begin
                if (keycode == 8'h1A)
                    m_sel = (m_sel + 2) % 3;
                else if (keycode == 8'h16)
                    m_sel = (m_sel + 1) % 3;
                else if (keycode == 8'h28) begin
                    m_valid  = 1;
                    m_locked = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("idx", 32'(index_out), 32'(m_idx[2]));
            chk("blank", 32'(blank_out), 32'(m_blk[2]));
            chk("sel", 32'(sel_id), 32'(m_sel));
            chk("valid", 32'(sel_valid), 32'(m_valid));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pix(input int x, input int y, input logic b);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        blank_in = b;
    endtask

    task automatic hold_pix(input string name, input int x, input int y,
                            input logic b, input logic [3:0] exp);
        pix(x, y, b);
        step(3);
        chk(name, 32'(index_out), 32'(exp));
    endtask

    task automatic press(input logic [7:0] k, input int hold);
        keycode = k;
        step(hold);
        keycode = 8'h00;
        step(2);
    endtask

    initial begin
        int vcnt;
        logic [1:0] vsel;

        step(3);
        chk("rst_idx", 32'(index_out), 32'h0);
        chk("rst_blank", 32'(blank_out), 32'h0);
        chk("rst_sel", 32'(sel_id), 32'h0);
        chk("rst_valid", 32'(sel_valid), 32'h0);

        Reset_n = 1'b1;
        pix(0, 0, 1'b1);
        step(2);
        chk("lat_blank_early", 32'(blank_out), 32'h0);
        step(1);
        chk("lat_blank", 32'(blank_out), 32'h1);
        chk("lat_idx", 32'(index_out), 32'h7);
        chk("pin_model", 32'(m_idx[2]), 32'h7);

        for (int x = 4; x <= 8; x++) begin
            pix(x, 8, 1'b1);
            step(1);
        end
        hold_pix("addr321", 7, 8, 1'b1, 4'h6);
        hold_pix("addr322", 8, 8, 1'b1, 4'h7);
        hold_pix("addr481", 4, 12, 1'b1, 4'hE);
        hold_pix("border", 240, 210, 1'b1, 4'h1);
        hold_pix("blanked", 300, 210, 1'b0, 4'h0);
        hold_pix("out_range", 700, 100, 1'b1, 4'h7);
        hold_pix("hl_sel0", 300, 210, 1'b1, 4'h3);
        hold_pix("nohl_btn1", 300, 270, 1'b1, 4'h4);

        press(8'h16, 100);
        chk("held_once", 32'(sel_id), 32'h1);
        hold_pix("nohl_sel1", 300, 210, 1'b1, 4'h4);
        hold_pix("hl_sel1", 300, 270, 1'b1, 4'h3);
        press(8'h16, 3);
        chk("down_2", 32'(sel_id), 32'h2);
        press(8'h16, 3);
        chk("down_wrap", 32'(sel_id), 32'h0);
        press(8'h1A, 3);
        chk("up_wrap", 32'(sel_id), 32'h2);

        keycode = 8'h28;
        vcnt = 0;
        vsel = 2'd3;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (sel_valid) begin
                vcnt++;
                vsel = sel_id;
            end
        end
        keycode = 8'h00;
        step(2);
        chk("valid_pulses", 32'(vcnt), 32'h1);
        chk("valid_sel", 32'(vsel), 32'h2);
        press(8'h1A, 3);
        press(8'h1A, 3);
        chk("locked_hold", 32'(sel_id), 32'h2);
        hold_pix("hl_locked", 300, 330, 1'b1, 4'h3);

        menu_en = 1'b0;
        step(2);
        chk("menu_off", 32'(sel_id), 32'h0);
        menu_en = 1'b1;
        step(1);
        press(8'h1A, 3);
        chk("unlocked_up", 32'(sel_id), 32'h2);
        keycode = 8'h1A;
        menu_en = 1'b0;
        step(1);
        chk("menu_prio", 32'(sel_id), 32'h0);
        keycode = 8'h00;
        step(2);
        press(8'h16, 3);
        chk("menu_off_keys", 32'(sel_id), 32'h0);
        menu_en = 1'b1;
        step(2);

        press(8'h16, 3);
        pix(0, 0, 1'b1);
        step(4);
        chk("pre_rst_sel", 32'(sel_id), 32'h1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_idx", 32'(index_out), 32'h0);
        chk("async_blank", 32'(blank_out), 32'h0);
        chk("async_sel", 32'(sel_id), 32'h0);
        chk("async_valid", 32'(sel_valid), 32'h0);
        step(2);
        Reset_n = 1'b1;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/menu_index_fetch.md
Name: menu_index_fetch

Overview:
- Upstream feeder of the menu palette lookup stage.
- Turns the VGA controller's pixel coordinates into a 4-bit palette index per pixel, read from a 4x-downscaled menu image ROM.
- Substitutes a highlight index over the currently selected menu button.
- Owns the keyboard-driven button-selection state machine; index_out drives the palette's index input directly.

Parameters:
- IMG_W, 160, stored image width in ROM texels (screen 640 / 4)
- IMG_H, 120, stored image height in texels (screen 480 / 4)
- INDEX_BG, 4'h4, button-face index eligible for highlight substitution
- INDEX_HL, 4'h3, index substituted inside the selected button
- BLINK_LOG2, 4, frames per blink half-period = 2**BLINK_LOG2 (optional feature only)

Ports:
- Clk  in  1  pixel clock, 25 MHz, one pixel per cycle
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column, 0..799
- DrawY  in  10  current pixel row, 0..524
- blank_in  in  1  1 = visible pixel, 0 = blanking
- menu_en  in  1  1 = menu screen active
- keycode  in  8  USB HID keycode, 0x00 = no key
- index_out  out  4  palette index, aligned with blank_out
- blank_out  out  1  blank_in delayed by 3 cycles
- sel_id  out  2  currently highlighted button, 0..2
- sel_valid  out  1  one-cycle pulse when a button is confirmed

Behaviour:
- Reset (async, Reset_n=0): all pipeline registers 0, index_out=0, blank_out=0, sel_id=0, sel_valid=0, FSM=SEL0, key_prev=0.
- Pipeline, 3 cycles fixed latency, no stalls:
  - S1: register addr = (DrawY>>2)*IMG_W + (DrawX>>2), 15 bits, plus in_btn[2:0] (pixel inside each button rectangle) and blank.
  - S2: registered ROM read; data available one cycle after addr.
  - S3: index_out = ROM data, replaced by INDEX_HL when in_btn[sel_id]==1, data==INDEX_BG and hl_on==1.
  - Out-of-range pixels (DrawX>=640 or DrawY>=480): S1 forces addr=0 and in_btn=0.
  - When the delayed blank is 0, index_out=0.
- Button rectangles are inclusive screen-coordinate bounds: x 240..399 for all three; y 200..239, 260..299, 320..359 for buttons 0, 1, 2.
- Key edge detection:
  - Act only when keycode!=0 and key_prev==0; key_prev is registered every cycle.
  - A held key acts once; auto-repeat is ignored until the key is released.
- FSM states SEL0, SEL1, SEL2, LOCKED; sel_id tracks the current SEL state.
  - W (0x1A) moves up, wrapping SEL0->SEL2. S (0x16) moves down, wrapping SEL2->SEL0.
  - Enter (0x28) in SELn: sel_valid=1 for exactly one cycle with sel_id=n, then go to LOCKED.
  - LOCKED ignores all keys; sel_id and the highlight hold.
  - Other keycodes: no effect.
- menu_en=0: synchronously go to SEL0, sel_valid=0, all key events ignored. This takes priority over a simultaneous key edge in the same cycle.
- LOCKED exits only via menu_en=0.
- hl_on=1 constantly when the optional feature is absent.
- sel_id changes take effect on the pixel in S1 on the cycle after the change. Mid-frame tearing is acceptable.

Optional Feature:
- Macro: MENU_BLINK_EN
- Defined:
  - A frame counter of BLINK_LOG2+1 bits increments on the cycle where DrawX==0 and DrawY==0.
  - hl_on = counter MSB, so the highlight toggles every 16 frames.
  - In LOCKED, hl_on is forced to 1.
  - Counter resets to 0, then increments.
- Undefined: no counter; hl_on tied to 1.

Decomposition:
- Package menu_pkg:
  - Keycode constants KEY_W, KEY_S, KEY_ENTER.
  - Button rectangle bound constants (3x x0/x1/y0/y1).
  - FSM enum menu_sel_t {SEL0, SEL1, SEL2, LOCKED}.
  - IMG_W and IMG_H defaults.
- One sub-module, menu_rom:
  - 19200x4 synchronous-read ROM, initialised from the menu image memory file.
  - Ports: Clk, addr[14:0], data[3:0].
  - No reset on the data register.

Test Plan:
- Reset then release; drive DrawX=0,DrawY=0,blank_in=1 with ROM[0]=4'h7 -> index_out=4'h7 and blank_out=1 exactly 3 cycles later; all outputs 0 during reset.
- Sweep DrawX=4..7, DrawY=8 -> all four pixels read ROM address 2*160+1=321.
- Pixel (300,210), ROM value INDEX_BG, sel_id=0 -> index_out=INDEX_HL. Same pixel with sel_id=1 -> INDEX_BG.
- keycode 0x16 held 100 cycles -> sel_id 0->1 once. Release, press 0x16 twice -> sel_id 2 then 0 (wrap).
- keycode 0x28 in SEL2 -> sel_valid high exactly 1 cycle with sel_id=2. Further 0x1A presses -> no change.
- Press 0x1A in the same cycle menu_en falls -> sel_id=0, no move.
- Assert Reset_n=0 mid-line -> outputs 0 immediately without waiting for a clock edge.
